// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle controller.
// It holds the FSM state encoding, the datapath select codes, the ALU command
// decode and the ARM condition codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    // ALUControl codes
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // ResultSrc codes
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // ALUSrcB codes
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ImmSrc codes
    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    // Instr[27:26] opcode classes
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing commands, Instr[24:21]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition field, Instr[31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Unknown commands fall back to ADD so the ALU still does something benign.
    function automatic logic [1:0] alu_ctrl_of(input logic [3:0] cmd);
        logic [1:0] ctrl;
        case (cmd)
            CMD_ADD:          ctrl = ALU_ADD;
            CMD_SUB, CMD_CMP: ctrl = ALU_SUB;
            CMD_AND:          ctrl = ALU_AND;
            CMD_ORR:          ctrl = ALU_ORR;
            default:          ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/cond_unit.sv
// cond_unit: NZCV flags register plus the ARM condition-code evaluation.
// Flags are {N,Z,C,V} in bits [3:0]. Logical ops update only N and Z.
module cond_unit
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_alu_flags,
    input  logic       i_flag_we,
    input  logic       i_nz_only,
    output logic       o_cond_ex
);

    logic [3:0] r_flags;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Flags register: cleared by reset, C/V kept on logical-op updates
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flags <= 4'b0000;
        end else if (i_flag_we) begin
            if (i_nz_only) begin
                r_flags[3:2] <= i_alu_flags[3:2];
            end else begin
                r_flags <= i_alu_flags;
            end
        end
    end

    // Condition decode against the current flags; NV never executes
    always_comb begin
        o_cond_ex = 1'b0;
        case (i_cond)
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = ~w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = ~w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = ~w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = ~w_v;
            COND_HI: o_cond_ex = w_c & ~w_z;
            COND_LS: o_cond_ex = ~w_c | w_z;
            COND_GE: o_cond_ex = (w_n == w_v);
            COND_LT: o_cond_ex = (w_n != w_v);
            COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
            COND_LE: o_cond_ex = w_z | (w_n != w_v);
            COND_AL: o_cond_ex = 1'b1;
            default: o_cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore FSM for a multicycle ARM-subset datapath.
// Optional macro MC_CTRL_STALL_EN adds input mem_ready. FETCH, MEMRD and MEMWR
// then wait for memory, and their write strobes fire only in the ready cycle.
// Handshake: mem_ready is sampled in FETCH/MEMRD/MEMWR. A cycle with
// mem_ready=1 completes the access and advances. A cycle with mem_ready=0 holds
// the state and suppresses IRWrite/PCWrite/MemWrite.
// The write enables are gated by rst so that they drop as soon as reset asserts.
module mc_controller
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
`ifdef MC_CTRL_STALL_EN
    input  logic        mem_ready,
`endif
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  state
);

    state_t     r_state;
    logic       r_exec_cond;

    logic       w_ready;
    logic       w_cond_ex;
    logic [1:0] w_op;
    logic       w_imm;
    logic [3:0] w_cmd;
    logic       w_l_s;
    logic       w_is_cmp;
    logic       w_set_flags;
    logic       w_logical;
    logic       w_rd_pc;
    logic       w_in_exec;
    logic       w_flag_we;
    logic       w_unused_instr;

    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_write;

`ifdef MC_CTRL_STALL_EN
    assign w_ready = mem_ready;
`else
    assign w_ready = 1'b1;
`endif

    // Rn and the immediate/register operand bits belong to the datapath only
    assign w_unused_instr = ^{Instr[19:16], Instr[11:0]};

    assign w_op        = Instr[27:26];
    assign w_imm       = Instr[25];
    assign w_cmd       = Instr[24:21];
    assign w_l_s       = Instr[20];
    assign w_is_cmp    = (w_cmd == CMD_CMP);
    assign w_set_flags = w_l_s | w_is_cmp;
    assign w_logical   = (w_cmd == CMD_AND) | (w_cmd == CMD_ORR);
    assign w_rd_pc     = (Instr[15:12] == 4'hF);
    assign w_in_exec   = (r_state == S_EXECR) | (r_state == S_EXECI);
    assign w_flag_we   = w_in_exec & w_set_flags & w_cond_ex;

    cond_unit u_cond (
        .clk         (clk),
        .rst         (rst),
        .i_cond      (Instr[31:28]),
        .i_alu_flags (ALUFlags),
        .i_flag_we   (w_flag_we),
        .i_nz_only   (w_logical),
        .o_cond_ex   (w_cond_ex)
    );

    // State sequencing; also keeps the EXEC-cycle condition so ALUWB is not
    // affected by the flags this same instruction just wrote
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_FETCH;
            r_exec_cond <= 1'b0;
        end else begin
            if (w_in_exec) begin
                r_exec_cond <= w_cond_ex;
            end
            case (r_state)
                S_FETCH: begin
                    if (w_ready) r_state <= S_DECODE;
                end
                S_DECODE: begin
                    case (w_op)
                        OP_MEM:  r_state <= S_MEMADR;
                        OP_BR:   r_state <= S_BRANCH;
                        OP_DP:   r_state <= w_imm ? S_EXECI : S_EXECR;
                        default: r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: r_state <= w_l_s ? S_MEMRD : S_MEMWR;
                S_MEMRD: begin
                    if (w_ready) r_state <= S_MEMWB;
                end
                S_MEMWB: r_state <= S_FETCH;
                S_MEMWR: begin
                    if (w_ready) r_state <= S_FETCH;
                end
                S_EXECR, S_EXECI: r_state <= S_ALUWB;
                S_ALUWB, S_BRANCH: r_state <= S_FETCH;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Moore output decode from state and Instr; anything not named stays 0
    always_comb begin
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ResultSrc   = RES_ALUOUT;
        ImmSrc      = IMM_DP;
        RegSrc      = 2'b00;
        ALUControl  = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_ir_write = w_ready;
                w_pc_write = w_ready;
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURES;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_MEM;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc   = RES_DATA;
                w_reg_write = w_cond_ex;
                w_pc_write  = w_cond_ex & w_rd_pc;
            end
            S_MEMWR: begin
                AdrSrc      = 1'b1;
                w_mem_write = w_cond_ex & w_ready;
            end
            S_EXECR: begin
                ALUSrcB    = SRCB_REG;
                ALUControl = alu_ctrl_of(w_cmd);
            end
            S_EXECI: begin
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_DP;
                ALUControl = alu_ctrl_of(w_cmd);
            end
            S_ALUWB: begin
                ResultSrc   = RES_ALUOUT;
                w_reg_write = r_exec_cond & ~w_is_cmp;
                w_pc_write  = r_exec_cond & ~w_is_cmp & w_rd_pc;
            end
            S_BRANCH: begin
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_BR;
                RegSrc     = 2'b01;
                ResultSrc  = RES_ALURES;
                w_pc_write = w_cond_ex;
            end
            default: begin
            end
        endcase
    end

    assign PCWrite  = rst & w_pc_write;
    assign IRWrite  = rst & w_ir_write;
    assign RegWrite = rst & w_reg_write;
    assign MemWrite = rst & w_mem_write;
    assign state    = r_state;

endmodule
